// File: rtl/nubus_master_fsm.sv
// NuBus master transaction sequencer.
// Runs one local request through arbitration, address cycle, data wait and
// optional locked continuation. It then closes a locked sequence with an
// attention cycle. The active-low state-decode strobes are registered from the
// next state, so the downstream driver stage sees glitch-free levels that match
// the current state.
module nubus_master_fsm #(
    parameter int ARB_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       nub_clkn,
    input  logic       nub_reset,
    // local request side
    input  logic       cpu_valid,
    input  logic [1:0] cpu_tm,
    input  logic       cpu_lock,
    output logic       cpu_ready,
    output logic       cpu_err,
    // bus side
    input  logic       arb_grant,
    input  logic       nub_startn,
    input  logic       nub_ackn,
    output logic       mst_arbcyn,
    output logic       mst_adrcyn,
    output logic       mst_dtacyn,
    output logic       mst_ownern,
    output logic       mst_lockedn,
    output logic       mst_tm1n,
    output logic       mst_tm0n,
    output logic       mst_timeout
);

    // The arbitration counter only has to reach ARB_CYCLES, because it saturates there.
    localparam int ARB_W = (ARB_CYCLES < 1) ? 1 : $clog2(ARB_CYCLES + 1);
    localparam logic [ARB_W-1:0] ARB_MAX = ARB_W'(ARB_CYCLES);
    // The data-wait counter starts at 0 on the first DATA clock.
    // The terminal clock is therefore count TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_DATA,
        S_ATTN
    } state_t;

    state_t            state, state_nxt;
    logic [ARB_W-1:0]  arb_cnt, arb_cnt_nxt, arb_inc;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [1:0]        tm_q, tm_nxt;
    logic              lock_q, lock_nxt;
    logic              bus_busy, bus_busy_nxt;
    logic              ack_seen;
    logic              to_terminal;
    logic              ready_nxt, err_nxt;
    logic              arbcyn_nxt, adrcyn_nxt, dtacyn_nxt, ownern_nxt;
    logic              lockedn_nxt, tm1n_nxt, tm0n_nxt;

    assign ack_seen    = ~nub_ackn;
    assign arb_inc     = (arb_cnt >= ARB_MAX) ? ARB_MAX : arb_cnt + ARB_W'(1);
    assign to_terminal = (state == S_DATA) && (to_cnt == TO_LAST);

    // The timeout strobe belongs to the terminal DATA clock itself.
    // It is suppressed when ACK* is sampled in that same clock.
    assign mst_timeout = to_terminal & ~ack_seen;

    // Another master's bus tenure runs from its START* to the next ACK*.
    // A START* in the same cycle as an ACK* marks the bus as busy.
    always_comb begin
        bus_busy_nxt = bus_busy;
        if (!nub_startn && mst_ownern) begin
            bus_busy_nxt = 1'b1;
        end else if (ack_seen) begin
            bus_busy_nxt = 1'b0;
        end
    end

    // Next-state logic, plus the counter, tm and lock latch updates.
    always_comb begin
        // NOTE: every signal gets a default before the case. If an arm leaves a
        // signal unassigned, the signal then holds its value on purpose instead
        // of inferring a latch.
        state_nxt   = state;
        arb_cnt_nxt = arb_cnt;
        to_cnt_nxt  = to_cnt;
        tm_nxt      = tm_q;
        lock_nxt    = lock_q;
        ready_nxt   = 1'b0;
        err_nxt     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (cpu_valid) begin
                    tm_nxt      = cpu_tm;
                    lock_nxt    = cpu_lock;
                    arb_cnt_nxt = '0;
                    state_nxt   = S_ARB;
                end
            end

            S_ARB: begin
                // Losing the grant throws away any arbitration time already spent.
                if (!arb_grant) begin
                    arb_cnt_nxt = '0;
                end else begin
                    arb_cnt_nxt = arb_inc;
                    if ((arb_inc >= ARB_MAX) && !bus_busy) begin
                        state_nxt = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                to_cnt_nxt = '0;
                state_nxt  = S_DATA;
            end

            S_DATA: begin
                to_cnt_nxt = to_cnt + TO_W'(1);
                if (ack_seen) begin
                    ready_nxt = 1'b1;
                    if (lock_q && cpu_valid && cpu_lock) begin
                        // A locked continuation keeps ownership and goes straight back to ADDR.
                        tm_nxt    = cpu_tm;
                        state_nxt = S_ADDR;
                    end else if (lock_q) begin
                        state_nxt = S_ATTN;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (to_terminal) begin
                    err_nxt   = 1'b1;
                    state_nxt = lock_q ? S_ATTN : S_IDLE;
                end
            end

            S_ATTN: begin
                lock_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobe decode of the state being entered. It is registered below so that
    // the strobes line up with that state.
    always_comb begin
        arbcyn_nxt  = 1'b1;
        adrcyn_nxt  = 1'b1;
        dtacyn_nxt  = 1'b1;
        ownern_nxt  = 1'b1;
        lockedn_nxt = 1'b1;
        tm1n_nxt    = 1'b1;
        tm0n_nxt    = 1'b1;

        unique case (state_nxt)
            S_ARB: begin
                arbcyn_nxt = 1'b0;
            end

            S_ADDR: begin
                ownern_nxt  = 1'b0;
                arbcyn_nxt  = 1'b0;
                adrcyn_nxt  = 1'b0;
                lockedn_nxt = ~lock_nxt;
                tm1n_nxt    = ~tm_nxt[1];
                tm0n_nxt    = ~tm_nxt[0];
            end

            S_DATA: begin
                // A locked sequence keeps asserting arbitration so that ownership is not released.
                ownern_nxt  = 1'b0;
                dtacyn_nxt  = 1'b0;
                arbcyn_nxt  = ~lock_nxt;
                lockedn_nxt = ~lock_nxt;
                tm1n_nxt    = ~tm_nxt[1];
                tm0n_nxt    = ~tm_nxt[0];
            end

            S_ATTN: begin
                // Because lockedn is inactive here, the driver emits NULL-ATTN.
                ownern_nxt = 1'b0;
                arbcyn_nxt = 1'b0;
            end

            default: begin
            end
        endcase
    end

    // State register and the datapath latches that go with it.
    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples the pre-edge values, whatever the statement order.
        if (nub_reset) begin
            state    <= S_IDLE;
            arb_cnt  <= '0;
            to_cnt   <= '0;
            tm_q     <= 2'b00;
            lock_q   <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            arb_cnt  <= arb_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
            tm_q     <= tm_nxt;
            lock_q   <= lock_nxt;
            bus_busy <= bus_busy_nxt;
        end
    end

    // Registered strobes and the one-cycle completion pulses.
    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            mst_arbcyn  <= 1'b1;
            mst_adrcyn  <= 1'b1;
            mst_dtacyn  <= 1'b1;
            mst_ownern  <= 1'b1;
            mst_lockedn <= 1'b1;
            mst_tm1n    <= 1'b1;
            mst_tm0n    <= 1'b1;
            cpu_ready   <= 1'b0;
            cpu_err     <= 1'b0;
        end else begin
            mst_arbcyn  <= arbcyn_nxt;
            mst_adrcyn  <= adrcyn_nxt;
            mst_dtacyn  <= dtacyn_nxt;
            mst_ownern  <= ownern_nxt;
            mst_lockedn <= lockedn_nxt;
            mst_tm1n    <= tm1n_nxt;
            mst_tm0n    <= tm0n_nxt;
            cpu_ready   <= ready_nxt;
            cpu_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_nubus_master_fsm.sv
// Bench for nubus_master_fsm: a vector table, hand-written corner-case
// sequences and random traffic, all compared against a transaction-level model.
module tb_nubus_master_fsm;

    localparam int ARB_CYC = 2;
    localparam int TO_CYC  = 4;
    // Output vector, MSB first: ready err arbcyn adrcyn dtacyn ownern lockedn tm1n tm0n timeout
    localparam logic [9:0] RST_VEC = 10'b0011111110;

    typedef struct packed {
        bit       valid;
        bit [1:0] tm;
        bit       lock;
        bit       grant;
        bit       startn;
        bit       ackn;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    logic       nub_clkn = 1'b0;
    logic       nub_reset = 1'b1;
    logic       cpu_valid = 1'b0;
    logic [1:0] cpu_tm = 2'b00;
    logic       cpu_lock = 1'b0;
    logic       arb_grant = 1'b0;
    logic       nub_startn = 1'b1;
    logic       nub_ackn = 1'b1;
    logic       cpu_ready, cpu_err;
    logic       mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern;
    logic       mst_lockedn, mst_tm1n, mst_tm0n, mst_timeout;

    int errors = 0;
    int checks = 0;
    logic [9:0] obs;

    nubus_master_fsm #(
        .ARB_CYCLES    (ARB_CYC),
        .TIMEOUT_CYCLES(TO_CYC),
        .TO_W          (8)
    ) dut (
        .nub_clkn   (nub_clkn),
        .nub_reset  (nub_reset),
        .cpu_valid  (cpu_valid),
        .cpu_tm     (cpu_tm),
        .cpu_lock   (cpu_lock),
        .cpu_ready  (cpu_ready),
        .cpu_err    (cpu_err),
        .arb_grant  (arb_grant),
        .nub_startn (nub_startn),
        .nub_ackn   (nub_ackn),
        .mst_arbcyn (mst_arbcyn),
        .mst_adrcyn (mst_adrcyn),
        .mst_dtacyn (mst_dtacyn),
        .mst_ownern (mst_ownern),
        .mst_lockedn(mst_lockedn),
        .mst_tm1n   (mst_tm1n),
        .mst_tm0n   (mst_tm0n),
        .mst_timeout(mst_timeout)
    );

    always #5 nub_clkn = ~nub_clkn;

    // ---------------- reference model ----------------
    // The model tracks which bus phase the transaction is in, how long the grant
    // has been held, and which data clock the transaction has reached.
    localparam int PH_IDLE = 0, PH_ARB = 1, PH_ADDR = 2, PH_DATA = 3, PH_ATTN = 4;
    int       m_phase;
    bit       m_busy;
    bit [1:0] m_tm;
    bit       m_lock;
    int       m_streak;
    int       m_wait;
    bit       m_ready, m_err;

    function automatic void model_reset();
        m_phase  = PH_IDLE;
        m_busy   = 1'b0;
        m_tm     = 2'b00;
        m_lock   = 1'b0;
        m_streak = 0;
        m_wait   = 0;
        m_ready  = 1'b0;
        m_err    = 1'b0;
    endfunction

    function automatic bit model_owns();
        return (m_phase == PH_ADDR) || (m_phase == PH_DATA) || (m_phase == PH_ATTN);
    endfunction

    function automatic logic [9:0] model_vec(input bit ackn);
        bit arb = 1, adr = 1, dta = 1, own = 1, lck = 1, t1 = 1, t0 = 1, to = 0;
        case (m_phase)
            PH_ARB:  arb = 0;
            PH_ADDR: begin
                own = 0; arb = 0; adr = 0;
                lck = ~m_lock; t1 = ~m_tm[1]; t0 = ~m_tm[0];
            end
            PH_DATA: begin
                own = 0; dta = 0; arb = ~m_lock;
                lck = ~m_lock; t1 = ~m_tm[1]; t0 = ~m_tm[0];
                to = ackn && (m_wait == TO_CYC);
            end
            PH_ATTN: begin
                own = 0; arb = 0;
            end
            default: ;
        endcase
        return {m_ready, m_err, arb, adr, dta, own, lck, t1, t0, to};
    endfunction

    function automatic void model_step(input in_t i);
        bit nb = m_busy;
        if (!i.startn && !model_owns()) nb = 1'b1;
        else if (!i.ackn) nb = 1'b0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        case (m_phase)
            PH_IDLE: if (i.valid) begin
                m_tm = i.tm; m_lock = i.lock; m_streak = 0; m_phase = PH_ARB;
            end
            PH_ARB: begin
                m_streak = i.grant ? m_streak + 1 : 0;
                if (i.grant && m_streak >= ARB_CYC && !m_busy) m_phase = PH_ADDR;
            end
            PH_ADDR: begin
                m_phase = PH_DATA;
                m_wait  = 1;
            end
            PH_DATA: begin
                if (!i.ackn) begin
                    m_ready = 1'b1;
                    if (m_lock && i.valid && i.lock) begin
                        m_tm = i.tm; m_phase = PH_ADDR;
                    end else begin
                        m_phase = m_lock ? PH_ATTN : PH_IDLE;
                    end
                end else if (m_wait == TO_CYC) begin
                    m_err   = 1'b1;
                    m_phase = m_lock ? PH_ATTN : PH_IDLE;
                end else begin
                    m_wait++;
                end
            end
            PH_ATTN: begin
                m_lock  = 1'b0;
                m_phase = PH_IDLE;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_busy = nb;
    endfunction

    // ---------------- helpers ----------------
    function automatic in_t mk_in(input bit v, input bit [1:0] tm, input bit lk,
                                  input bit g, input bit s, input bit a);
        in_t r;
        r.valid = v; r.tm = tm; r.lock = lk; r.grant = g; r.startn = s; r.ackn = a;
        return r;
    endfunction

    function automatic vec_t mk_vec(input in_t i, input logic [9:0] e);
        vec_t r;
        r.in = i; r.exp = e;
        return r;
    endfunction

    function automatic logic [9:0] dut_vec();
        return {cpu_ready, cpu_err, mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern,
                mst_lockedn, mst_tm1n, mst_tm0n, mst_timeout};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic apply(input in_t i);
        cpu_valid  = i.valid;
        cpu_tm     = i.tm;
        cpu_lock   = i.lock;
        arb_grant  = i.grant;
        nub_startn = i.startn;
        nub_ackn   = i.ackn;
    endtask

    // This task runs one clock. It drives the inputs at the falling edge,
    // samples just after, checks against the model and the optional table
    // value, and then advances the model.
    task automatic cyc(input in_t i, input bit use_exp, input logic [9:0] exp, input string name);
        @(negedge nub_clkn);
        apply(i);
        #1;
        obs = dut_vec();
        check({name, "/model"}, obs, model_vec(i.ackn));
        if (use_exp) check(name, obs, exp);
        model_step(i);
    endtask

    task automatic do_reset();
        @(negedge nub_clkn);
        nub_reset = 1'b1;
        apply(mk_in(0, 2'b00, 0, 1, 1, 1));
        #1;
        model_reset();
        check("reset", dut_vec(), RST_VEC);
        @(negedge nub_clkn);
        nub_reset = 1'b0;
    endtask

    vec_t tbl[14];

    initial begin
        in_t idle_in, ri;
        int  rdy;

        idle_in = mk_in(0, 2'b00, 0, 1, 1, 1);
        // The first block is an unlocked read with tm=00 and ACK on the 3rd DATA
        // clock. The second block is an unlocked tm=10 transfer with an immediate ACK.
        tbl[0]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 1), 10'b0011111110);
        tbl[1]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 1), 10'b0001111110);
        tbl[2]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 1), 10'b0001111110);
        tbl[3]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 1), 10'b0000101110);
        tbl[4]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 1), 10'b0011001110);
        tbl[5]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 1), 10'b0011001110);
        tbl[6]  = mk_vec(mk_in(1, 2'b00, 0, 1, 1, 0), 10'b0011001110);
        tbl[7]  = mk_vec(mk_in(0, 2'b00, 0, 1, 1, 1), 10'b1011111110);
        tbl[8]  = mk_vec(mk_in(1, 2'b10, 0, 1, 1, 1), 10'b0011111110);
        tbl[9]  = mk_vec(mk_in(1, 2'b10, 0, 1, 1, 1), 10'b0001111110);
        tbl[10] = mk_vec(mk_in(1, 2'b10, 0, 1, 1, 1), 10'b0001111110);
        tbl[11] = mk_vec(mk_in(1, 2'b10, 0, 1, 1, 1), 10'b0000101010);
        tbl[12] = mk_vec(mk_in(1, 2'b10, 0, 1, 1, 0), 10'b0011001010);
        tbl[13] = mk_vec(mk_in(0, 2'b00, 0, 1, 1, 1), 10'b1011111110);

        model_reset();
        apply(idle_in);
        repeat (2) @(negedge nub_clkn);
        check("reset_state", dut_vec(), RST_VEC);
        nub_reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            cyc(tbl[k].in, 1'b1, tbl[k].exp, $sformatf("vec%0d", k));
        end

        // This sequence never sees ACK, so the timeout fires on the 4th DATA clock only.
        cyc(mk_in(1, 2'b11, 0, 1, 1, 1), 0, '0, "to_idle");
        repeat (2) cyc(mk_in(1, 2'b11, 0, 1, 1, 1), 0, '0, "to_arb");
        cyc(mk_in(1, 2'b11, 0, 1, 1, 1), 0, '0, "to_addr");
        check("to_addr_tm", 10'(obs[2:1]), 10'(2'b00));
        for (int k = 1; k <= 4; k++) begin
            cyc(mk_in(1, 2'b11, 0, 1, 1, 1), 0, '0, "to_data");
            check($sformatf("to_strobe_d%0d", k), 10'(obs[0]), 10'(k == 4));
        end
        cyc(idle_in, 0, '0, "to_after");
        check("to_err_pulse", 10'(obs[9:8]), 10'(2'b01));
        cyc(idle_in, 0, '0, "to_after2");
        check("to_err_once", 10'(obs[9:8]), 10'(2'b00));

        // In this sequence, ACK arrives on the terminal count and wins.
        cyc(mk_in(1, 2'b01, 0, 1, 1, 1), 0, '0, "tk_idle");
        repeat (3) cyc(mk_in(1, 2'b01, 0, 1, 1, 1), 0, '0, "tk_arb_addr");
        repeat (3) cyc(mk_in(1, 2'b01, 0, 1, 1, 1), 0, '0, "tk_data");
        cyc(mk_in(1, 2'b01, 0, 1, 1, 0), 0, '0, "tk_term");
        check("tk_no_timeout", 10'(obs[0]), 10'(0));
        cyc(idle_in, 0, '0, "tk_after");
        check("tk_ready_not_err", 10'(obs[9:8]), 10'(2'b10));

        // In this sequence, a locked pair ends with an attention cycle.
        rdy = 0;
        cyc(mk_in(1, 2'b01, 1, 1, 1, 1), 0, '0, "lk_idle");
        repeat (2) cyc(mk_in(1, 2'b01, 1, 1, 1, 1), 0, '0, "lk_arb");
        cyc(mk_in(1, 2'b01, 1, 1, 1, 1), 0, '0, "lk_addr1");
        check("lk_addr1_strb", 10'(obs[7:1]), 10'(7'b0010010));
        cyc(mk_in(1, 2'b10, 1, 1, 1, 0), 0, '0, "lk_data1");
        check("lk_data1_arb", 10'(obs[7]), 10'(0));
        cyc(mk_in(0, 2'b00, 0, 1, 1, 1), 0, '0, "lk_addr2");
        rdy += int'(obs[9]);
        check("lk_addr2_strb", 10'(obs[7:1]), 10'(7'b0010001));
        cyc(mk_in(0, 2'b00, 0, 1, 1, 0), 0, '0, "lk_data2");
        check("lk_data2_arb", 10'(obs[7]), 10'(0));
        cyc(idle_in, 0, '0, "lk_attn");
        rdy += int'(obs[9]);
        check("lk_attn_strb", 10'(obs[7:1]), 10'(7'b0110111));
        cyc(idle_in, 0, '0, "lk_end");
        check("lk_end_idle", obs, RST_VEC);
        check("lk_ready_count", 10'(rdy), 10'(2));

        // In this sequence, another master holds the bus from START* until its ACK* five clocks later.
        cyc(mk_in(1, 2'b00, 0, 1, 1, 1), 0, '0, "bz_idle");
        cyc(mk_in(1, 2'b00, 0, 1, 0, 1), 0, '0, "bz_arb1");
        repeat (4) cyc(mk_in(1, 2'b00, 0, 1, 1, 1), 0, '0, "bz_arb_wait");
        cyc(mk_in(1, 2'b00, 0, 1, 1, 0), 0, '0, "bz_arb6");
        check("bz_still_arb6", 10'(obs[7:6]), 10'(2'b01));
        cyc(mk_in(1, 2'b00, 0, 1, 1, 1), 0, '0, "bz_arb7");
        check("bz_still_arb7", 10'(obs[7:6]), 10'(2'b01));
        cyc(mk_in(1, 2'b00, 0, 1, 1, 1), 0, '0, "bz_addr");
        check("bz_addr_now", 10'(obs[6]), 10'(0));
        cyc(mk_in(1, 2'b00, 0, 1, 1, 0), 0, '0, "bz_data");
        repeat (2) cyc(idle_in, 0, '0, "bz_done");

        // In this sequence, reset is asserted in the middle of DATA with ACK pending.
        cyc(mk_in(1, 2'b11, 1, 1, 1, 1), 0, '0, "rs_idle");
        repeat (4) cyc(mk_in(1, 2'b11, 1, 1, 1, 1), 0, '0, "rs_to_data");
        @(posedge nub_clkn);
        #1 nub_ackn = 1'b0;
        #1 nub_reset = 1'b1;
        #1;
        check("rs_async", dut_vec(), RST_VEC);
        model_reset();
        @(negedge nub_clkn);
        apply(idle_in);
        nub_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(idle_in, 0, '0, "rs_after");
            check("rs_no_pulse", 10'(obs[9:8]), 10'(2'b00));
        end

        // Random traffic compared against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                ri = mk_in($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8,
                           $urandom_range(0, 9) != 0, $urandom_range(0, 9) >= 3);
                cyc(ri, 0, '0, "rnd");
                if (obs[9] && obs[8]) check("rnd_ready_err_excl", 10'(obs[9] & obs[8]), 10'(0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nubus_master_fsm.md
Name: nubus_master_fsm

Overview:
- Master-side transaction sequencer for the NuBus card.
- Accepts one local request at a time and runs the sequence arbitration -> address cycle (START*) -> data wait for ACK* -> optional locked continuation -> attention cycle.
- Produces the active-low state-decode strobes consumed directly by the downstream NuBus driver stage: arbitration, address, data, owner, locked, TM1/TM0 and timeout.

Parameters:
- ARB_CYCLES, 2, minimum clocks spent in ARB before ownership may be taken.
- TIMEOUT_CYCLES, 255, data-cycle clocks without ACK* before mst_timeout fires. Legal range 1..255.
- TO_W, 8, timeout counter width.

Ports:
- nub_clkn  in  1  NuBus clock; all state updates on rising edge.
- nub_reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  transaction request, held until cpu_ready or cpu_err.
- cpu_tm  in  2  transfer mode {TM1,TM0}, active-high.
- cpu_lock  in  1  keep bus ownership after this transaction.
- cpu_ready  out  1  one-cycle pulse: transaction acknowledged.
- cpu_err  out  1  one-cycle pulse: transaction timed out.
- arb_grant  in  1  this card won the ID arbitration (from arbiter).
- nub_startn  in  1  sampled NuBus START*.
- nub_ackn  in  1  sampled NuBus ACK*.
- mst_arbcyn  out  1  arbitration cycle active (low).
- mst_adrcyn  out  1  address cycle active (low).
- mst_dtacyn  out  1  data cycle active (low).
- mst_ownern  out  1  this card owns the bus (low).
- mst_lockedn  out  1  locked sequence in progress (low).
- mst_tm1n  out  1  latched TM1, inverted.
- mst_tm0n  out  1  latched TM0, inverted.
- mst_timeout  out  1  one-cycle timeout strobe (high).

Behaviour:
- Reset (async, immediate): state IDLE. All *n outputs 1. mst_timeout=0, cpu_ready=0, cpu_err=0. Counters 0. bus_busy=0. tm latch 2'b00.
- bus_busy flag:
  - Set when nub_startn=0 is sampled while mst_ownern=1.
  - Cleared when nub_ackn=0 is sampled.
  - Set has priority if both occur in the same cycle.
- IDLE:
  - Outputs inactive.
  - On cpu_valid=1: latch cpu_tm and cpu_lock, clear arb counter, go to ARB.
- ARB:
  - mst_arbcyn=0; arb counter increments, saturating at ARB_CYCLES.
  - Go to ADDR when counter>=ARB_CYCLES, arb_grant=1 and bus_busy=0, all in the same cycle; otherwise stay.
  - If arb_grant drops, the counter restarts from 0.
- ADDR (exactly 1 clock):
  - mst_ownern=0, mst_arbcyn=0, mst_adrcyn=0, mst_dtacyn=1.
  - mst_tm1n/mst_tm0n = ~latched tm.
  - mst_lockedn = ~latched lock.
  - Timeout counter cleared. Next state DATA.
- DATA:
  - mst_ownern=0, mst_dtacyn=0, mst_adrcyn=1.
  - mst_arbcyn=0 only if locked, otherwise 1.
  - mst_tm*n hold their values.
  - nub_ackn=0 sampled -> cpu_ready pulse next cycle.
    - If locked and cpu_valid=1 with cpu_lock=1 in that same cycle: re-latch tm, go to ADDR with no re-arbitration.
    - Else if locked: go to ATTN.
    - Else: go to IDLE.
  - Counter reaching TIMEOUT_CYCLES without ACK -> mst_timeout=1 for exactly that cycle and cpu_err pulse next cycle. Next state: ATTN if locked, else IDLE.
  - ACK arriving on the same cycle as the terminal count wins; no timeout is raised.
- ATTN (exactly 1 clock):
  - mst_ownern=0, mst_arbcyn=0, mst_adrcyn=1, mst_dtacyn=1.
  - mst_lockedn=1, which makes the driver emit NULL-ATTN.
  - Next state IDLE. The lock latch is cleared.
- cpu_ready and cpu_err are never both 1 in the same cycle.
- Reset asserted in any state aborts immediately; no ATTN cycle is emitted.
- Output decodes are registered from state (glitch-free), matching the driver's combinational decode.

Test Plan:
- Unlocked read, tm=2'b00, grant held high, ACK at 3rd DATA clock -> ARB 2 clocks, ADDR 1 clock (adrcyn=0, tm1n=tm0n=1), DATA 3 clocks, cpu_ready=1 one cycle, back to IDLE, all *n outputs 1.
- No ACK, TIMEOUT_CYCLES=4 -> mst_timeout=1 on 4th DATA clock only, cpu_err pulse, cpu_ready stays 0, IDLE.
- Locked pair, cpu_lock=1 twice, ACK after 1 clock each -> ARB, ADDR, DATA, ADDR, DATA (arbcyn=0 throughout), then ATTN with lockedn=1 and ownern=0, then IDLE; two cpu_ready pulses.
- Another master's START* low during our ARB, its ACK* 5 clocks later -> stay in ARB until the clock after ACK* is sampled, then ADDR.
- Reset asserted mid-DATA -> all outputs return to reset values asynchronously; no cpu_ready or cpu_err pulse.
- ACK* and terminal timeout count in the same cycle -> cpu_ready=1, mst_timeout=0, cpu_err=0.
